// File: rtl/pkt_cache_pkg.sv
// Shared constants and types for the packet store-and-forward cache.
// Header-type codes live in the top two bits of every packet word.
package pkt_cache_pkg;

    localparam int WORD_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } rd_state_t;

    function automatic logic [1:0] word_hdr(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/cache_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
// Read data is presented from the head entry so a pop can inspect the word it removes.
module cache_sync_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             wr_ok;
    logic             rd_ok;

    // A push into a full FIFO is dropped; the caller sees it via the full flag.
    assign wr_ok = wr_en & ~full_reg;
    assign rd_ok = rd_en & ~empty_reg;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/pkt_cache.sv
// Store-and-forward packet buffer: holds whole packets, drops flagged ones,
// streams kept packets out under a ready handshake and drives almost-full upstream.
module pkt_cache
    import pkt_cache_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int VDEPTH    = 64,
    parameter int ALF_LEVEL = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_cache_data_wr,
    input  logic [WORD_W-1:0] in_cache_data,
    input  logic              in_cache_valid_wr,
    input  logic              in_cache_valid,
    output logic              out_cache_data_alf,
    output logic              pktout_data_wr,
    output logic [WORD_W-1:0] pktout_data,
    output logic              pktout_valid_wr,
    output logic              pktout_valid,
    input  logic              pktout_ready,
    output logic [31:0]       cache_in_pkt_cnt,
    output logic [31:0]       cache_out_pkt_cnt,
    output logic [31:0]       cache_drop_cnt,
    output logic              cache_err
);

    localparam int DCW = $clog2(DEPTH) + 1;
    localparam int VCW = $clog2(VDEPTH) + 1;
    localparam logic [DCW-1:0] ALF_D = DCW'(ALF_LEVEL);
    localparam logic [VCW-1:0] ALF_V = VCW'(VDEPTH - 4);

    logic              in_pkt_reg;
    logic              word_accept;
    logic              valid_accept;
    logic [1:0]        hdr_in;

    logic [WORD_W-1:0] d_rd_data;
    logic [DCW-1:0]    d_count;
    logic              d_full;
    logic              d_empty;
    logic [0:0]        v_rd_data;
    logic [VCW-1:0]    v_count;
    logic              v_full;
    logic              v_empty;

    rd_state_t         state_reg;
    logic              send_pop;
    logic              drop_pop;
    logic              d_pop;
    logic              tail_pop;

    logic              pktout_data_wr_reg;
    logic [WORD_W-1:0] pktout_data_reg;
    logic              pktout_valid_wr_reg;
    logic              err_reg;
    logic [2:0]        cnt_inc;

    // Words are only taken once a head has been seen, so a packet cut short by
    // reset is not half-stored; the flag strobe rides on an accepted tail.
    assign hdr_in       = word_hdr(in_cache_data);
    assign word_accept  = in_cache_data_wr & ((hdr_in == HDR_HEAD) | in_pkt_reg);
    assign valid_accept = in_cache_valid_wr & in_pkt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt_reg <= 1'b0;
        end else if (word_accept) begin
            if (hdr_in == HDR_HEAD) begin
                in_pkt_reg <= 1'b1;
            end else if (hdr_in == HDR_TAIL) begin
                in_pkt_reg <= 1'b0;
            end
        end
    end

    cache_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (word_accept),
        .wr_data (in_cache_data),
        .rd_en   (d_pop),
        .rd_data (d_rd_data),
        .count   (d_count),
        .full    (d_full),
        .empty   (d_empty)
    );

    cache_sync_fifo #(
        .WIDTH (1),
        .DEPTH (VDEPTH)
    ) u_valid_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_accept),
        .wr_data (in_cache_valid),
        .rd_en   (tail_pop),
        .rd_data (v_rd_data),
        .count   (v_count),
        .full    (v_full),
        .empty   (v_empty)
    );

    always_comb begin
        send_pop = (state_reg == SEND) & pktout_ready & ~d_empty;
        drop_pop = (state_reg == DROP) & ~d_empty;
        d_pop    = send_pop | drop_pop;
        tail_pop = d_pop & (word_hdr(d_rd_data) == HDR_TAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            pktout_data_wr_reg  <= 1'b0;
            pktout_data_reg     <= '0;
            pktout_valid_wr_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!v_empty) begin
                        if (v_rd_data[0] && pktout_ready) begin
                            state_reg <= SEND;
                        end else if (!v_rd_data[0]) begin
                            state_reg <= DROP;
                        end
                    end
                end
                SEND, DROP: begin
                    if (tail_pop) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            pktout_data_wr_reg  <= send_pop;
            pktout_valid_wr_reg <= send_pop & tail_pop;
            if (send_pop) begin
                pktout_data_reg <= d_rd_data;
            end
        end
    end

    // Overflow is sticky: a discarded push on either FIFO leaves a permanent mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((word_accept & d_full) | (valid_accept & v_full)) begin
            err_reg <= 1'b1;
        end
    end

    assign cnt_inc[0] = valid_accept;
    assign cnt_inc[1] = send_pop & tail_pop;
    assign cnt_inc[2] = drop_pop & tail_pop;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign cache_in_pkt_cnt   = g_cnt[0].cnt_reg;
    assign cache_out_pkt_cnt  = g_cnt[1].cnt_reg;
    assign cache_drop_cnt     = g_cnt[2].cnt_reg;

    assign out_cache_data_alf = (d_count >= ALF_D) | (v_count >= ALF_V);
    assign pktout_data_wr     = pktout_data_wr_reg;
    assign pktout_data        = pktout_data_reg;
    assign pktout_valid_wr    = pktout_valid_wr_reg;
    assign pktout_valid       = pktout_valid_wr_reg;
    assign cache_err          = err_reg;

endmodule
